// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the instruction-cache refill controller.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      FILL  = 2'd2,
      WRITE = 2'd3
   } icache_state_t;

   localparam int WORD_W = 32;

   // One line is a packed array of these; word k sits at bits [32k+31:32k].
   typedef logic [WORD_W-1:0] word_t;

   function automatic int off_w(input int block_words);
      return $clog2(block_words) + 2;
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int block_words, input int sets);
      return addr_w - off_w(block_words) - idx_w(sets);
   endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Direct-mapped valid/tag store: combinational lookup, single write port, invalidate-all.
module icache_tag_array
   import icache_pkg::*;
#(
   parameter  int SETS  = 32,
   parameter  int TAG_W = 23,
   localparam int IDX_W = idx_w(SETS)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   input  logic [TAG_W-1:0] rd_tag_i,
   output logic             hit_o,
   input  logic             we_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic [TAG_W-1:0] wr_tag_i,
   input  logic             inv_all_i
);

   logic [SETS-1:0]  valid_q;
   logic [TAG_W-1:0] tag_q [SETS];

   // Invalidate wins over a same-edge line write, so a line refilled while a
   // flush was pending ends up invalid.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q <= '0;
      end else if (inv_all_i) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   // NOTE: the tag storage has no reset; valid_q gates every use, so clearing
   // it would only add reset fan-out to a RAM-like structure.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         tag_q[wr_idx_i] <= wr_tag_i;
      end
   end

   assign hit_o = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);

endmodule

// File: rtl/icache_refill_ctrl.sv
// Fetch-stage I-cache controller: lookup, miss detection and line refill over a request/beat bus.
module icache_refill_ctrl
   import icache_pkg::*;
#(
   parameter  int ADDR_W      = 32,
   parameter  int BLOCK_WORDS = 4,
   parameter  int SETS        = 32,
   localparam int OFF_W       = off_w(BLOCK_WORDS),
   localparam int IDX_W       = idx_w(SETS),
   localparam int TAG_W       = tag_w(ADDR_W, BLOCK_WORDS, SETS)
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic [ADDR_W-1:0]           pc_f_i,
   input  logic                        branch_pending_i,
   input  logic                        inv_i,
   output logic                        mem_req_o,
   output logic [ADDR_W-1:0]           mem_addr_o,
   input  logic                        mem_ready_i,
   input  logic                        mem_rvalid_i,
   input  logic [31:0]                 mem_rdata_i,
   output logic                        fill_we_o,
   output logic [IDX_W-1:0]            fill_set_o,
   output logic [32*BLOCK_WORDS-1:0]   fill_data_o,
   output logic                        instr_hit_f_o,
   output logic                        ic_repl_permit_o,
   output logic                        busy_o
);

   localparam int CNT_W = $clog2(BLOCK_WORDS);

   typedef word_t [BLOCK_WORDS-1:0] line_t;

   icache_state_t     state_q, state_d;
   logic [ADDR_W-1:0] miss_addr_q;
   logic [CNT_W-1:0]  cnt_q;
   line_t             line_q;
   logic              inv_pending_q;
   logic              hit;
   logic              inv_all;
   logic              start;
   logic              last_beat;

   // Byte-offset bits of the PC never take part in lookup or request.
   logic unused_pc_off;
   assign unused_pc_off = ^pc_f_i[OFF_W-1:0];

   icache_tag_array #(
      .SETS  (SETS),
      .TAG_W (TAG_W)
   ) u_tags (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .rd_idx_i  (pc_f_i[OFF_W+IDX_W-1:OFF_W]),
      .rd_tag_i  (pc_f_i[ADDR_W-1:OFF_W+IDX_W]),
      .hit_o     (hit),
      .we_i      (fill_we_o),
      .wr_idx_i  (miss_addr_q[OFF_W+IDX_W-1:OFF_W]),
      .wr_tag_i  (miss_addr_q[ADDR_W-1:OFF_W+IDX_W]),
      .inv_all_i (inv_all)
   );

   assign start     = (state_q == IDLE) && !hit && !branch_pending_i && !inv_pending_q && !inv_i;
   assign last_beat = mem_rvalid_i && (cnt_q == CNT_W'(BLOCK_WORDS - 1));
   assign inv_all   = ((state_q == IDLE) && inv_i) ||
                      ((state_q == WRITE) && (inv_pending_q || inv_i));

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start)       state_d = REQ;
         REQ:     if (mem_ready_i) state_d = FILL;
         FILL:    if (last_beat)   state_d = WRITE;
         WRITE:                    state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments here so every flop samples pre-edge values
   // regardless of statement order.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= IDLE;
         miss_addr_q   <= '0;
         cnt_q         <= '0;
         line_q        <= '0;
         inv_pending_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start) begin
            miss_addr_q <= {pc_f_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
         end
         if ((state_q == REQ) && mem_ready_i) begin
            cnt_q <= '0;
         end else if ((state_q == FILL) && mem_rvalid_i) begin
            line_q[cnt_q] <= mem_rdata_i;
            cnt_q         <= cnt_q + 1'b1;
         end
         if (state_q == WRITE) begin
            inv_pending_q <= 1'b0;
         end else if ((state_q != IDLE) && inv_i) begin
            inv_pending_q <= 1'b1;
         end
      end
   end

   // Fill outputs come straight from registers, so they hold until the next miss capture.
   assign mem_req_o        = (state_q == REQ);
   assign mem_addr_o       = miss_addr_q;
   assign fill_we_o        = (state_q == WRITE);
   assign fill_set_o       = miss_addr_q[OFF_W+IDX_W-1:OFF_W];
   assign fill_data_o      = line_q;
   assign instr_hit_f_o    = hit;
   assign ic_repl_permit_o = !((state_q == IDLE) && branch_pending_i);
   assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed, table-driven bench for icache_refill_ctrl (BLOCK_WORDS=4, SETS=32).
module tb_icache_refill_ctrl;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic [31:0]   pc_f_i;
   logic          branch_pending_i;
   logic          inv_i;
   logic          mem_req_o;
   logic [31:0]   mem_addr_o;
   logic          mem_ready_i;
   logic          mem_rvalid_i;
   logic [31:0]   mem_rdata_i;
   logic          fill_we_o;
   logic [4:0]    fill_set_o;
   logic [127:0]  fill_data_o;
   logic          instr_hit_f_o;
   logic          ic_repl_permit_o;
   logic          busy_o;

   int checks   = 0;
   int failures = 0;

   icache_refill_ctrl #(
      .ADDR_W      (32),
      .BLOCK_WORDS (4),
      .SETS        (32)
   ) dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .pc_f_i           (pc_f_i),
      .branch_pending_i (branch_pending_i),
      .inv_i            (inv_i),
      .mem_req_o        (mem_req_o),
      .mem_addr_o       (mem_addr_o),
      .mem_ready_i      (mem_ready_i),
      .mem_rvalid_i     (mem_rvalid_i),
      .mem_rdata_i      (mem_rdata_i),
      .fill_we_o        (fill_we_o),
      .fill_set_o       (fill_set_o),
      .fill_data_o      (fill_data_o),
      .instr_hit_f_o    (instr_hit_f_o),
      .ic_repl_permit_o (ic_repl_permit_o),
      .busy_o           (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0]  pc;
      logic         bp;
      logic         inv;
      logic         rdy;
      logic         rv;
      logic [31:0]  rd;
      logic         req;
      logic [31:0]  addr;
      logic         we;
      logic [4:0]   set;
      logic [127:0] data;
      logic         hit;
      logic         permit;
      logic         busy;
   } vec_t;

   localparam logic [127:0] LINE_A = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
   localparam logic [127:0] LINE_B = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
   localparam logic [127:0] LINE_D = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
   localparam logic [127:0] LINE_E = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
   localparam logic [127:0] LINE_F = {32'hF3, 32'hF2, 32'hF1, 32'hF0};

   vec_t tbl[$];

   function automatic vec_t v(input logic [31:0] pc, input logic bp, input logic inv,
                              input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic req, input logic [31:0] addr, input logic we,
                              input logic [4:0] set, input logic [127:0] data,
                              input logic hit, input logic permit, input logic busy);
      vec_t e;
      e.pc = pc;   e.bp = bp;     e.inv = inv;   e.rdy = rdy; e.rv = rv; e.rd = rd;
      e.req = req; e.addr = addr; e.we = we;     e.set = set; e.data = data;
      e.hit = hit; e.permit = permit; e.busy = busy;
      return e;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Called just after a rising edge: drive inputs, compare on the falling edge,
   // then advance to just after the next rising edge.
   task automatic cyc(input vec_t e, input string name);
      pc_f_i           = e.pc;
      branch_pending_i = e.bp;
      inv_i            = e.inv;
      mem_ready_i      = e.rdy;
      mem_rvalid_i     = e.rv;
      mem_rdata_i      = e.rd;
      @(negedge clk_i);
      check({name, "/req"},    128'(mem_req_o),        128'(e.req));
      check({name, "/we"},     128'(fill_we_o),        128'(e.we));
      check({name, "/hit"},    128'(instr_hit_f_o),    128'(e.hit));
      check({name, "/permit"}, 128'(ic_repl_permit_o), 128'(e.permit));
      check({name, "/busy"},   128'(busy_o),           128'(e.busy));
      if (e.req) check({name, "/addr"}, 128'(mem_addr_o), 128'(e.addr));
      if (e.we) begin
         check({name, "/set"},  128'(fill_set_o), 128'(e.set));
         check({name, "/data"}, fill_data_o,      e.data);
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      reset_i          = 1'b1;
      pc_f_i           = 32'h100;
      branch_pending_i = 1'b0;
      inv_i            = 1'b0;
      mem_ready_i      = 1'b0;
      mem_rvalid_i     = 1'b0;
      mem_rdata_i      = '0;

      // Cold miss on 0x100 (set 0x10): request at c1, accept at c3, beats c4-c7, write c8, hit c9.
      tbl.push_back(v(32'h100, 0, 0, 0, 0, 0,     0, 0,      0, 0,     0,      0, 1, 0)); // c0
      tbl.push_back(v(32'h100, 0, 0, 0, 0, 0,     1, 32'h100, 0, 0,    0,      0, 1, 1)); // c1
      tbl.push_back(v(32'h100, 0, 0, 0, 0, 0,     1, 32'h100, 0, 0,    0,      0, 1, 1)); // c2
      tbl.push_back(v(32'h100, 0, 0, 1, 0, 0,     1, 32'h100, 0, 0,    0,      0, 1, 1)); // c3
      tbl.push_back(v(32'h100, 0, 0, 0, 1, 'hA0,  0, 0,      0, 0,     0,      0, 1, 1)); // c4
      tbl.push_back(v(32'h100, 0, 0, 0, 1, 'hA1,  0, 0,      0, 0,     0,      0, 1, 1)); // c5
      tbl.push_back(v(32'h100, 0, 0, 0, 1, 'hA2,  0, 0,      0, 0,     0,      0, 1, 1)); // c6
      tbl.push_back(v(32'h100, 0, 0, 0, 1, 'hA3,  0, 0,      0, 0,     0,      0, 1, 1)); // c7
      tbl.push_back(v(32'h100, 0, 0, 0, 0, 0,     0, 0,      1, 5'h10, LINE_A, 0, 1, 1)); // c8
      tbl.push_back(v(32'h100, 0, 0, 0, 0, 0,     0, 0,      0, 0,     0,      1, 1, 0)); // c9
      // Conflict: 0x300 maps to set 0x10 and replaces 0x100.
      tbl.push_back(v(32'h300, 0, 0, 0, 0, 0,     0, 0,      0, 0,     0,      0, 1, 0)); // c10
      tbl.push_back(v(32'h300, 0, 0, 1, 0, 0,     1, 32'h300, 0, 0,    0,      0, 1, 1)); // c11
      tbl.push_back(v(32'h300, 0, 0, 0, 1, 'hB0,  0, 0,      0, 0,     0,      0, 1, 1)); // c12
      tbl.push_back(v(32'h300, 0, 0, 0, 1, 'hB1,  0, 0,      0, 0,     0,      0, 1, 1)); // c13
      tbl.push_back(v(32'h300, 0, 0, 0, 1, 'hB2,  0, 0,      0, 0,     0,      0, 1, 1)); // c14
      tbl.push_back(v(32'h300, 0, 0, 0, 1, 'hB3,  0, 0,      0, 0,     0,      0, 1, 1)); // c15
      tbl.push_back(v(32'h300, 0, 0, 0, 0, 0,     0, 0,      1, 5'h10, LINE_B, 0, 1, 1)); // c16
      tbl.push_back(v(32'h300, 0, 0, 0, 0, 0,     0, 0,      0, 0,     0,      1, 1, 0)); // c17
      // 0x100 now misses but branch_pending holds it off for five cycles.
      for (int i = 0; i < 5; i++)
         tbl.push_back(v(32'h100, 1, 0, 0, 0, 0,  0, 0,      0, 0,     0,      0, 0, 0)); // c18-c22
      tbl.push_back(v(32'h100, 0, 0, 0, 0, 0,     0, 0,      0, 0,     0,      0, 1, 0)); // c23
      tbl.push_back(v(32'h100, 0, 0, 1, 0, 0,     1, 32'h100, 0, 0,    0,      0, 1, 1)); // c24
      // PC moves to 0x200 after two beats; fill still completes for 0x100.
      tbl.push_back(v(32'h100, 0, 0, 0, 1, 'hD0,  0, 0,      0, 0,     0,      0, 1, 1)); // c25
      tbl.push_back(v(32'h100, 0, 0, 0, 1, 'hD1,  0, 0,      0, 0,     0,      0, 1, 1)); // c26
      tbl.push_back(v(32'h200, 0, 0, 0, 1, 'hD2,  0, 0,      0, 0,     0,      0, 1, 1)); // c27
      tbl.push_back(v(32'h200, 0, 0, 0, 1, 'hD3,  0, 0,      0, 0,     0,      0, 1, 1)); // c28
      tbl.push_back(v(32'h200, 0, 0, 0, 0, 0,     0, 0,      1, 5'h10, LINE_D, 0, 1, 1)); // c29
      tbl.push_back(v(32'h200, 0, 0, 0, 0, 0,     0, 0,      0, 0,     0,      0, 1, 0)); // c30
      tbl.push_back(v(32'h200, 0, 0, 1, 0, 0,     1, 32'h200, 0, 0,    0,      0, 1, 1)); // c31
      tbl.push_back(v(32'h200, 0, 0, 0, 1, 'hE0,  0, 0,      0, 0,     0,      0, 1, 1)); // c32
      tbl.push_back(v(32'h200, 0, 0, 0, 1, 'hE1,  0, 0,      0, 0,     0,      0, 1, 1)); // c33
      tbl.push_back(v(32'h200, 0, 0, 0, 1, 'hE2,  0, 0,      0, 0,     0,      0, 1, 1)); // c34
      tbl.push_back(v(32'h200, 0, 0, 0, 1, 'hE3,  0, 0,      0, 0,     0,      0, 1, 1)); // c35
      tbl.push_back(v(32'h200, 0, 0, 0, 0, 0,     0, 0,      1, 5'h00, LINE_E, 0, 1, 1)); // c36
      tbl.push_back(v(32'h200, 0, 0, 0, 0, 0,     0, 0,      0, 0,     0,      1, 1, 0)); // c37
      tbl.push_back(v(32'h100, 0, 0, 0, 0, 0,     0, 0,      0, 0,     0,      1, 1, 0)); // c38

      repeat (2) @(posedge clk_i);
      #1;
      check("rst/req",  128'(mem_req_o),     128'(0));
      check("rst/we",   128'(fill_we_o),     128'(0));
      check("rst/hit",  128'(instr_hit_f_o), 128'(0));
      check("rst/busy", 128'(busy_o),        128'(0));
      reset_i = 1'b0;

      foreach (tbl[i]) cyc(tbl[i], $sformatf("c%0d", i));

      // Invalidate during FILL of 0x180 (set 0x18): write still happens, then everything is invalid.
      cyc(v(32'h180, 0, 0, 0, 0, 0,     0, 0,       0, 0,     0,      0, 1, 0), "inv0");
      cyc(v(32'h180, 0, 0, 1, 0, 0,     1, 32'h180, 0, 0,     0,      0, 1, 1), "inv1");
      cyc(v(32'h180, 0, 1, 0, 1, 'hF0,  0, 0,       0, 0,     0,      0, 1, 1), "inv2");
      cyc(v(32'h180, 0, 0, 0, 1, 'hF1,  0, 0,       0, 0,     0,      0, 1, 1), "inv3");
      cyc(v(32'h180, 0, 0, 0, 1, 'hF2,  0, 0,       0, 0,     0,      0, 1, 1), "inv4");
      cyc(v(32'h180, 0, 0, 0, 1, 'hF3,  0, 0,       0, 0,     0,      0, 1, 1), "inv5");
      cyc(v(32'h100, 0, 0, 0, 0, 0,     0, 0,       1, 5'h18, LINE_F, 1, 1, 1), "inv6");
      cyc(v(32'h100, 0, 0, 0, 0, 0,     0, 0,       0, 0,     0,      0, 1, 0), "inv7");
      cyc(v(32'h100, 0, 0, 1, 0, 0,     1, 32'h100, 0, 0,     0,      0, 1, 1), "inv8");

      // Reset mid-FILL; late beats must not produce a write or wake the FSM.
      cyc(v(32'h100, 0, 0, 0, 1, 'h50,  0, 0,       0, 0,     0,      0, 1, 1), "rf0");
      reset_i = 1'b1;
      cyc(v(32'h100, 0, 0, 0, 1, 'h51,  0, 0,       0, 0,     0,      0, 1, 0), "rf1");
      reset_i = 1'b0;
      cyc(v(32'h100, 1, 0, 0, 1, 'h52,  0, 0,       0, 0,     0,      0, 0, 0), "rf2");
      cyc(v(32'h100, 1, 0, 0, 1, 'h53,  0, 0,       0, 0,     0,      0, 0, 0), "rf3");
      cyc(v(32'h100, 1, 0, 0, 0, 0,     0, 0,       0, 0,     0,      0, 0, 0), "rf4");
      cyc(v(32'h100, 0, 0, 0, 0, 0,     0, 0,       0, 0,     0,      0, 1, 0), "rf5");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
